processing_element_ws_db: RTL

//   Weight-stationary systolic PE with a double-buffered (shadow/active) weight register.
//   The next column weight set shifts into the shadow buffers while the active weights compute.

---
 rtl/processing_element_ws_db_pkg.sv | 23 ++
 rtl/processing_element_ws_db_if.sv | 29 ++
 rtl/processing_element_ws_db_mac_sat.sv | 63 ++++++
 rtl/processing_element_ws_db.sv | 82 ++++++++
 4 files changed

// File: rtl/processing_element_ws_db_pkg.sv
// Shared defaults and saturation-bound helpers for the weight-stationary PE.
package processing_element_ws_db_pkg;

    localparam int unsigned PE_DEFAULT_WORD_WIDTH = 8;
    localparam int unsigned PE_DEFAULT_ACC_WIDTH  = 4 * PE_DEFAULT_WORD_WIDTH;
    localparam int unsigned PE_BOUND_WIDTH        = 64;

    // Largest two's-complement value of a w-bit word (w <= 64).
    function automatic logic [PE_BOUND_WIDTH-1:0] pe_smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest two's-complement value of a w-bit word, as its w-bit pattern.
    function automatic logic [PE_BOUND_WIDTH-1:0] pe_smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    // Largest unsigned value of a w-bit word.
    function automatic logic [PE_BOUND_WIDTH-1:0] pe_umax(input int unsigned w);
        return (w >= PE_BOUND_WIDTH) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/processing_element_ws_db_if.sv
// Systolic neighbour bus of one PE: weight chain, swap ripple, activations, partial sums.
interface processing_element_ws_db_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32
);
    logic                  en;
    logic                  w_load;
    logic [WORD_WIDTH-1:0] w_in;
    logic [WORD_WIDTH-1:0] w_out;
    logic                  w_swap_in;
    logic                  w_swap_out;
    logic [WORD_WIDTH-1:0] a_in;
    logic                  a_valid_in;
    logic [WORD_WIDTH-1:0] a_out;
    logic                  a_valid_out;
    logic [ACC_WIDTH-1:0]  d_in;
    logic [ACC_WIDTH-1:0]  d_out;
    logic                  d_valid_out;

    modport master (
        output en, w_load, w_in, w_swap_in, a_in, a_valid_in, d_in,
        input  w_out, w_swap_out, a_out, a_valid_out, d_out, d_valid_out
    );

    modport slave (
        input  en, w_load, w_in, w_swap_in, a_in, a_valid_in, d_in,
        output w_out, w_swap_out, a_out, a_valid_out, d_out, d_valid_out
    );
endinterface

// File: rtl/processing_element_ws_db_mac_sat.sv
// Combinational multiply-accumulate: sum = d + a*w, wrapping or saturating.
// ACC_WIDTH must be >= 2*WORD_WIDTH and <= 64.
module processing_element_ws_db_mac_sat
    import processing_element_ws_db_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = PE_DEFAULT_WORD_WIDTH,
    parameter int unsigned ACC_WIDTH  = 4 * WORD_WIDTH,
    parameter bit          SIGNED     = 1'b0,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] w,
    input  logic [ACC_WIDTH-1:0]  d,
    output logic [ACC_WIDTH-1:0]  sum
);
    localparam int unsigned PW = 2 * WORD_WIDTH;
    localparam int unsigned EW = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(pe_smax(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(pe_smin(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'(pe_umax(ACC_WIDTH));

    logic [PW-1:0] prod;
    logic [EW-1:0] p_ext;
    logic [EW-1:0] d_ext;
    logic [EW-1:0] s_ext;

    // Operand extension follows the arithmetic mode.
    if (SIGNED) begin : g_signed
        logic signed [PW-1:0] a_s;
        logic signed [PW-1:0] w_s;
        assign a_s   = PW'($signed(a));
        assign w_s   = PW'($signed(w));
        assign prod  = a_s * w_s;
        assign p_ext = EW'($signed(prod));
        assign d_ext = EW'($signed(d));
    end else begin : g_unsigned
        logic [PW-1:0] a_u;
        logic [PW-1:0] w_u;
        assign a_u   = PW'(a);
        assign w_u   = PW'(w);
        assign prod  = a_u * w_u;
        assign p_ext = EW'(prod);
        assign d_ext = EW'(d);
    end

    // One guard bit is enough: both addends already fit the ACC range.
    assign s_ext = p_ext + d_ext;

    // Clamp on overflow, otherwise keep the low ACC_WIDTH bits.
    always_comb begin
        sum = s_ext[ACC_WIDTH-1:0];
        if (SATURATE) begin
            if (SIGNED) begin
                if (s_ext[ACC_WIDTH] != s_ext[ACC_WIDTH-1]) begin
                    sum = s_ext[ACC_WIDTH] ? SMIN : SMAX;
                end
            end else if (s_ext[ACC_WIDTH]) begin
                sum = UMAX;
            end
        end
    end
endmodule

// File: rtl/processing_element_ws_db.sv
// Weight-stationary systolic PE with shadow/active weight double buffer.
module processing_element_ws_db
    import processing_element_ws_db_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = PE_DEFAULT_WORD_WIDTH,
    parameter int unsigned ACC_WIDTH  = 4 * WORD_WIDTH,
    parameter bit          SIGNED     = 1'b0,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    processing_element_ws_db_if.slave    bus
);
    logic [WORD_WIDTH-1:0] shadow_w_q, shadow_w_d;
    logic [WORD_WIDTH-1:0] active_w_q, active_w_d;
    logic                  swap_q,     swap_d;
    logic [WORD_WIDTH-1:0] a_q,        a_d;
    logic                  a_valid_q,  a_valid_d;
    logic [ACC_WIDTH-1:0]  d_q,        d_d;
    logic                  d_valid_q,  d_valid_d;
    logic [ACC_WIDTH-1:0]  mac_sum;

    processing_element_ws_db_mac_sat #(
        .WORD_WIDTH (WORD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED),
        .SATURATE   (SATURATE)
    ) u_mac (
        .a   (bus.a_in),
        .w   (active_w_q),
        .d   (bus.d_in),
        .sum (mac_sum)
    );

    // Next state: hold everything on stall; swap reads the pre-edge shadow value.
    always_comb begin
        shadow_w_d = shadow_w_q;
        active_w_d = active_w_q;
        swap_d     = swap_q;
        a_d        = a_q;
        a_valid_d  = a_valid_q;
        d_d        = d_q;
        d_valid_d  = d_valid_q;
        if (bus.en) begin
            if (bus.w_load)    shadow_w_d = bus.w_in;
            if (bus.w_swap_in) active_w_d = shadow_w_q;
            swap_d    = bus.w_swap_in;
            a_d       = bus.a_in;
            a_valid_d = bus.a_valid_in;
            d_valid_d = bus.a_valid_in;
            d_d       = bus.a_valid_in ? mac_sum : bus.d_in;
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_w_q <= '0;
            active_w_q <= '0;
            swap_q     <= 1'b0;
            a_q        <= '0;
            a_valid_q  <= 1'b0;
            d_q        <= '0;
            d_valid_q  <= 1'b0;
        end else begin
            shadow_w_q <= shadow_w_d;
            active_w_q <= active_w_d;
            swap_q     <= swap_d;
            a_q        <= a_d;
            a_valid_q  <= a_valid_d;
            d_q        <= d_d;
            d_valid_q  <= d_valid_d;
        end
    end

    assign bus.w_out       = shadow_w_q;
    assign bus.w_swap_out  = swap_q;
    assign bus.a_out       = a_q;
    assign bus.a_valid_out = a_valid_q;
    assign bus.d_out       = d_q;
    assign bus.d_valid_out = d_valid_q;
endmodule
